// File: rtl/commit_monitor.sv
// rtl/commit_monitor.sv - retirement monitor with shadow GPR file, ebreak drain/halt and watchdog
module commit_monitor #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned WDT_CYCLES   = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    output logic        commit_ready,
    input  logic [63:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic        commit_wen,
    input  logic [4:0]  commit_waddr,
    input  logic [63:0] commit_wdata,
    output logic [31:0] inst,
    output logic [63:0] last_pc,
    output logic [63:0] rf_0,  output logic [63:0] rf_1,  output logic [63:0] rf_2,  output logic [63:0] rf_3,
    output logic [63:0] rf_4,  output logic [63:0] rf_5,  output logic [63:0] rf_6,  output logic [63:0] rf_7,
    output logic [63:0] rf_8,  output logic [63:0] rf_9,  output logic [63:0] rf_10, output logic [63:0] rf_11,
    output logic [63:0] rf_12, output logic [63:0] rf_13, output logic [63:0] rf_14, output logic [63:0] rf_15,
    output logic [63:0] rf_16, output logic [63:0] rf_17, output logic [63:0] rf_18, output logic [63:0] rf_19,
    output logic [63:0] rf_20, output logic [63:0] rf_21, output logic [63:0] rf_22, output logic [63:0] rf_23,
    output logic [63:0] rf_24, output logic [63:0] rf_25, output logic [63:0] rf_26, output logic [63:0] rf_27,
    output logic [63:0] rf_28, output logic [63:0] rf_29, output logic [63:0] rf_30, output logic [63:0] rf_31,
    output logic        is_break,
    output logic [63:0] halt_code,
    output logic        timeout,
    output logic [63:0] instret,
    output logic [63:0] cycles
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

    state_t      state, state_nxt;
    logic [63:0] rf [1:31];
    logic [31:0] drain_cnt;
    logic [63:0] idle_cnt;
    logic        retire;
    logic        is_ebreak;
    logic        wdt_fire;
    logic [63:0] rf10_next;

    // Retire qualification, watchdog expiry and next-state selection
    always_comb begin
        retire    = commit_valid && (state == ST_RUN);
        is_ebreak = retire && (commit_inst == EBREAK);
        wdt_fire  = (WDT_CYCLES != 0) && (state == ST_RUN) && !retire &&
                    ((idle_cnt + 64'd1) == 64'(WDT_CYCLES));
        rf10_next = (retire && commit_wen && (commit_waddr == 5'd10)) ? commit_wdata : rf[10];
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (is_ebreak)
                    state_nxt = (DRAIN_CYCLES == 0) ? ST_HALT : ST_DRAIN;
                else if (wdt_fire)
                    state_nxt = ST_HALT;
            end
            ST_DRAIN: begin
                if (drain_cnt <= 32'd1)
                    state_nxt = ST_HALT;
            end
            ST_HALT:  state_nxt = ST_HALT;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // State, counters, shadow GPRs and halt status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            idle_cnt  <= '0;
            inst      <= '0;
            last_pc   <= '0;
            instret   <= '0;
            cycles    <= '0;
            is_break  <= 1'b0;
            timeout   <= 1'b0;
            halt_code <= '0;
            for (int i = 1; i < 32; i++) rf[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state != ST_HALT)
                cycles <= cycles + 64'd1;
            if (retire) begin
                inst     <= commit_inst;
                last_pc  <= commit_pc;
                instret  <= instret + 64'd1;
                idle_cnt <= '0;
                if (commit_wen && (commit_waddr != 5'd0))
                    rf[commit_waddr] <= commit_wdata;
            end else if (state == ST_RUN) begin
                idle_cnt <= idle_cnt + 64'd1;
            end
            if (is_ebreak)
                drain_cnt <= DRAIN_CYCLES;
            else if (state == ST_DRAIN)
                drain_cnt <= drain_cnt - 32'd1;
            if ((state != ST_HALT) && (state_nxt == ST_HALT)) begin
                is_break <= 1'b1;
                if (wdt_fire) begin
                    timeout   <= 1'b1;
                    halt_code <= '1;
                end else begin
                    halt_code <= rf10_next;
                end
            end
        end
    end

    assign commit_ready = (state == ST_RUN);

    assign rf_0  = '0;     assign rf_1  = rf[1];  assign rf_2  = rf[2];  assign rf_3  = rf[3];
    assign rf_4  = rf[4];  assign rf_5  = rf[5];  assign rf_6  = rf[6];  assign rf_7  = rf[7];
    assign rf_8  = rf[8];  assign rf_9  = rf[9];  assign rf_10 = rf[10]; assign rf_11 = rf[11];
    assign rf_12 = rf[12]; assign rf_13 = rf[13]; assign rf_14 = rf[14]; assign rf_15 = rf[15];
    assign rf_16 = rf[16]; assign rf_17 = rf[17]; assign rf_18 = rf[18]; assign rf_19 = rf[19];
    assign rf_20 = rf[20]; assign rf_21 = rf[21]; assign rf_22 = rf[22]; assign rf_23 = rf[23];
    assign rf_24 = rf[24]; assign rf_25 = rf[25]; assign rf_26 = rf[26]; assign rf_27 = rf[27];
    assign rf_28 = rf[28]; assign rf_29 = rf[29]; assign rf_30 = rf[30]; assign rf_31 = rf[31];

endmodule
